block_sync_6466b: RTL and testbench
===================================

// Module: block_sync_6466b
// PURPOSE
//  Aligns the raw 66-bit SerDes word stream onto 64b/66b block boundaries and runs
//  the clause-49 style block-lock state machine. Sits directly upstream of the
//  descrambler: emits the 2-bit sync header as ttype and the still-scrambled
//  64-bit payload as tdata. Only emits blocks while locked.
// PARAMETERS
//  LOCK_CNT   64  consecutive valid headers needed to declare lock; also the test window while locked
//  INVLD_MAX  16  invalid headers within one LOCK_CNT window that drop lock
//  SLIP_WAIT  2   accepted beats discarded after a slip before header testing resumes (>=1)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  s_axis_tdata   in   66  raw unaligned word, bit 0 received first
//  s_axis_tvalid  in   1   input word valid
//  s_axis_tready  out  1   equals m_axis_tready (combinational)
//  m_axis_ttype   out  2   sync header of aligned block (01 data, 10 ctrl, 00/11 illegal)
//  m_axis_tdata   out  64  aligned scrambled payload
//  m_axis_tvalid  out  1   aligned block valid
//  m_axis_tready  in   1   downstream ready
//  block_lock     out  1   1 = block lock acquired
//  bit_offset     out  7   current alignment offset, 0..65
// BEHAVIOUR
//  One clock, synchronous active-high reset; reset applies mid-operation with
//  the same values: m_axis_tvalid=0, block_lock=0, bit_offset=0, prev_valid=0,
//  counters=0, state=RESET_CNT; ttype/tdata are don't-care.
//  Beat = s_axis_tvalid & s_axis_tready. No state changes without a beat.
//  Window: prev = last accepted word. aligned[65:0] = ({s_axis_tdata, prev} >> bit_offset)[65:0].
//  Header = aligned[1:0], payload = aligned[65:2]. Header valid iff hdr[0]^hdr[1].
//  First beat after reset only loads prev (prev_valid<=1); it is not tested or emitted.
//  FSM (header test happens only on beats with prev_valid=1):
//   RESET_CNT: sh_cnt=0, invld=0 -> TEST_SH on the same beat (that beat's header is tested).
//   TEST_SH, unlocked: invalid -> SLIP. Valid -> sh_cnt++; on LOCK_CNT -> block_lock<=1, RESET_CNT.
//   TEST_SH, locked: sh_cnt++; invalid -> invld++. invld reaching INVLD_MAX -> block_lock<=0, SLIP
//     (takes priority over window end). Else sh_cnt==LOCK_CNT -> RESET_CNT (lock kept).
//   SLIP: bit_offset <= (bit_offset==65) ? 0 : bit_offset+1 on the same beat; wait_cnt<=SLIP_WAIT;
//     decrement per beat; at 0 -> RESET_CNT. Beats during the wait are not tested.
//  Output register, latency 1: updated only when m_axis_tready=1. On a beat:
//   tdata<=payload, ttype<=hdr, tvalid<=block_lock_next & prev_valid & tested_this_beat.
//   Lock-dropping block is not emitted; the lock-declaring block is emitted.
//   m_axis_tready=1 with no beat -> tvalid<=0. m_axis_tready=0 -> all outputs hold.
//  Counter widths: $clog2(LOCK_CNT+1), $clog2(INVLD_MAX+1), $clog2(SLIP_WAIT+1); no wrap.
// TESTING
//  Offset 0, always-valid headers, tready=1 -> block_lock rises on beat 65
//    (1 prev load + 64 tests); tvalid=1 from that block onward; payload matches.
//  Stream shifted by 37 bits -> bit_offset steps to 37 through slips; lock within
//    37*(SLIP_WAIT+1)+65 beats plus false-positive retries; aligned data correct.
//  Locked; inject 15 bad headers in one 64-window -> lock held, bit_offset unchanged;
//    16 in one window -> block_lock=0 on the 16th, bit_offset+1, tvalid=0.
//  Offset 65 plus one forced slip -> bit_offset wraps to 0.
//  Locked; toggle m_axis_tready low 5 cycles mid-stream -> s_axis_tready=0,
//    outputs frozen; no block lost or duplicated across the stall.
//  Locked; assert reset 1 cycle -> next cycle tvalid=0, block_lock=0, bit_offset=0;
//    relock takes 65 beats.

Source files
------------

// File: rtl/block_sync_6466b_if.sv
// Stream bundle for the 64b/66b block aligner: raw 66-bit words in, aligned blocks out.
// The slave modport is the aligner's view; the master modport is the environment's view.
interface block_sync_6466b_if;
  logic [65:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [1:0]  m_axis_ttype;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_ttype, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_ttype, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/block_sync_6466b.sv
// 64b/66b block aligner with block-lock state machine. Slides a 66-bit window over
// the last two accepted words, tests the sync header and slips one bit at a time
// until LOCK_CNT consecutive good headers are seen. Emits header + scrambled payload
// only while locked.
module block_sync_6466b #(
  parameter int LOCK_CNT  = 64,
  parameter int INVLD_MAX = 16,
  parameter int SLIP_WAIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  block_sync_6466b_if.slave  bus,
  output logic               block_lock,
  output logic [6:0]         bit_offset
);
  localparam int SHW = $clog2(LOCK_CNT + 1);
  localparam int IVW = $clog2(INVLD_MAX + 1);
  localparam int WW  = $clog2(SLIP_WAIT + 1);
  localparam logic [SHW-1:0] LOCK_V  = SHW'(LOCK_CNT);
  localparam logic [IVW-1:0] INVLD_V = IVW'(INVLD_MAX);
  localparam logic [WW-1:0]  WAIT_V  = WW'(SLIP_WAIT);
  localparam logic [WW-1:0]  WAIT_1  = WW'(1);

  typedef enum logic [1:0] {RESET_CNT, TEST_SH, SLIP} state_t;

  state_t         state, state_n;
  logic [65:0]    prev;
  logic           prev_valid;
  logic [SHW-1:0] sh_cnt, sh_n, sh_base, sh_inc;
  logic [IVW-1:0] invld, iv_n, iv_base, iv_inc;
  logic [WW-1:0]  wait_cnt, wait_n;
  logic           lock_n, slip, tested;
  logic [6:0]     off_n;
  logic [65:0]    aligned;
  logic [1:0]     hdr;
  logic           hdr_ok, beat;

  assign beat              = bus.s_axis_tvalid & bus.m_axis_tready;
  assign bus.s_axis_tready = bus.m_axis_tready;

  // Window extraction: prev sits in the low half so bit 0 of prev is the oldest bit.
  always_comb begin
    aligned = 66'({bus.s_axis_tdata, prev} >> bit_offset);
    hdr     = aligned[1:0];
    hdr_ok  = hdr[0] ^ hdr[1];
  end

  // Lock/slip decision for the current beat. RESET_CNT counts as a zeroed
  // TEST_SH so the beat that enters it is still tested.
  always_comb begin
    state_n = state;
    sh_n    = sh_cnt;
    iv_n    = invld;
    wait_n  = wait_cnt;
    lock_n  = block_lock;
    off_n   = bit_offset;
    slip    = 1'b0;
    tested  = beat & prev_valid & (state != SLIP);
    sh_base = (state == RESET_CNT) ? '0 : sh_cnt;
    iv_base = (state == RESET_CNT) ? '0 : invld;
    sh_inc  = sh_base + SHW'(1);
    iv_inc  = iv_base + {{(IVW-1){1'b0}}, ~hdr_ok};
    if (beat && prev_valid) begin
      case (state)
        RESET_CNT, TEST_SH: begin
          state_n = TEST_SH;
          sh_n    = sh_base;
          iv_n    = iv_base;
          if (!block_lock) begin
            if (!hdr_ok) slip = 1'b1;
            else begin
              sh_n = sh_inc;
              if (sh_inc == LOCK_V) begin
                lock_n  = 1'b1;
                state_n = RESET_CNT;
              end
            end
          end else begin
            sh_n = sh_inc;
            iv_n = iv_inc;
            // Too many bad headers wins over a window closing on the same beat.
            if (iv_inc == INVLD_V) begin
              lock_n = 1'b0;
              slip   = 1'b1;
            end else if (sh_inc == LOCK_V) begin
              state_n = RESET_CNT;
            end
          end
          if (slip) begin
            state_n = SLIP;
            wait_n  = WAIT_V;
            off_n   = (bit_offset == 7'd65) ? 7'd0 : bit_offset + 7'd1;
          end
        end
        default: begin
          // Discard beats while the new offset settles through prev.
          wait_n = wait_cnt - WW'(1);
          if (wait_cnt <= WAIT_1) state_n = RESET_CNT;
        end
      endcase
    end
  end

  // State, counters and the latency-1 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RESET_CNT;
      sh_cnt            <= '0;
      invld             <= '0;
      wait_cnt          <= '0;
      block_lock        <= 1'b0;
      bit_offset        <= 7'd0;
      prev_valid        <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_n;
      invld      <= iv_n;
      wait_cnt   <= wait_n;
      block_lock <= lock_n;
      bit_offset <= off_n;
      if (beat) begin
        prev       <= bus.s_axis_tdata;
        prev_valid <= 1'b1;
      end
      if (bus.m_axis_tready) begin
        if (beat) begin
          bus.m_axis_tdata  <= aligned[65:2];
          bus.m_axis_ttype  <= hdr;
          bus.m_axis_tvalid <= lock_n & tested;
        end else begin
          bus.m_axis_tvalid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_block_sync_6466b.sv
// Bench for block_sync_6466b: a serial bit source builds 64b/66b blocks behind a
// chosen number of garbage bits; a bit-position reference model predicts lock,
// offset and every emitted block.
module tb_block_sync_6466b;
  localparam int LOCK_CNT  = 64;
  localparam int INVLD_MAX = 16;
  localparam int SLIP_WAIT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       block_lock;
  logic [6:0] bit_offset;

  block_sync_6466b_if bus();

  block_sync_6466b #(.LOCK_CNT(LOCK_CNT), .INVLD_MAX(INVLD_MAX), .SLIP_WAIT(SLIP_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .block_lock(block_lock), .bit_offset(bit_offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit src[$];
  int bad_pending = 0;

  bit          m_pv, m_lock;
  int          m_off, m_skip, m_cnt, m_bad;
  logic [65:0] m_prev;
  bit          e_tv;
  logic [1:0]  e_tt;
  logic [63:0] e_td;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_block();
    logic [1:0]  h;
    logic [63:0] p;
    if (bad_pending > 0) begin
      h = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      bad_pending--;
    end else begin
      h = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    end
    p = {$urandom(), $urandom()};
    for (int i = 0; i < 2; i++)  src.push_back(h[i]);
    for (int i = 0; i < 64; i++) src.push_back(p[i]);
  endfunction

  function automatic logic [65:0] next_word();
    logic [65:0] w;
    while (src.size() < 66) push_block();
    for (int i = 0; i < 66; i++) w[i] = src.pop_front();
    return w;
  endfunction

  task automatic model_reset();
    m_pv = 0; m_lock = 0; m_off = 0; m_skip = 0; m_cnt = 0; m_bad = 0; e_tv = 0;
  endtask

  task automatic model_slip();
    m_off  = (m_off + 1) % 66;
    m_skip = SLIP_WAIT;
  endtask

  // Block at bit position m_off of the two most recent words, judged by the lock rules.
  task automatic model_beat(logic [65:0] w);
    logic [65:0] a;
    bit ok;
    if (!m_pv) begin
      m_pv = 1; e_tv = 0;
    end else if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin m_cnt = 0; m_bad = 0; end
      e_tv = 0;
    end else begin
      for (int i = 0; i < 66; i++) a[i] = (m_off + i < 66) ? m_prev[m_off + i] : w[m_off + i - 66];
      ok = (a[1:0] == 2'b01) || (a[1:0] == 2'b10);
      if (!m_lock) begin
        if (!ok) model_slip();
        else begin
          m_cnt++;
          if (m_cnt == LOCK_CNT) begin m_lock = 1; m_cnt = 0; m_bad = 0; end
        end
      end else begin
        m_cnt++;
        if (!ok) m_bad++;
        if (m_bad == INVLD_MAX) begin m_lock = 0; model_slip(); end
        else if (m_cnt == LOCK_CNT) begin m_cnt = 0; m_bad = 0; end
      end
      e_tv = m_lock; e_tt = a[1:0]; e_td = a[65:2];
    end
    m_prev = w;
  endtask

  task automatic check_out();
    chk("block_lock", 64'(block_lock), 64'(m_lock));
    chk("bit_offset", 64'(bit_offset), 64'(m_off));
    chk("tvalid", 64'(bus.m_axis_tvalid), 64'(e_tv));
    if (e_tv) begin
      chk("ttype", 64'(bus.m_axis_ttype), 64'(e_tt));
      chk("tdata", bus.m_axis_tdata, e_td);
    end
  endtask

  task automatic step(bit tv, bit tr);
    logic [65:0] w;
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    w = (tv && tr) ? next_word() : r[65:0];
    bus.s_axis_tdata  = w;
    bus.s_axis_tvalid = tv;
    bus.m_axis_tready = tr;
    #1 chk("s_tready", 64'(bus.s_axis_tready), 64'(tr));
    @(posedge clk); #1;
    if (tr) begin
      if (tv) model_beat(w);
      else    e_tv = 0;
    end
    check_out();
  endtask

  task automatic do_reset(int garbage);
    reset = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    src.delete();
    bad_pending = 0;
    for (int i = 0; i < garbage; i++) src.push_back(bit'($urandom_range(0, 1)));
    check_out();
  endtask

  // Advance until a fresh locked window has just started.
  task automatic wait_window();
    int n = 0;
    do begin
      step(1, 1);
      n++;
    end while (!(m_lock && m_cnt == 0) && n < 80);
    chk("window_sync", 64'(block_lock), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;

    // Reset state
    do_reset(0);
    chk("rst_lock", 64'(block_lock), 64'(0));
    chk("rst_off", 64'(bit_offset), 64'(0));
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));

    // Aligned stream: one prev load plus 64 tests
    for (int i = 1; i <= 65; i++) begin
      step(1, 1);
      if (i == 64) chk("lock_pre65", 64'(block_lock), 64'(0));
    end
    chk("lock_at65", 64'(block_lock), 64'(1));
    chk("tvalid_at65", 64'(bus.m_axis_tvalid), 64'(1));

    // Random valid gaps and downstream stalls
    repeat (150) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    // Five-cycle downstream stall mid-stream
    repeat (3) step(1, 1);
    repeat (5) step(1, 0);
    repeat (10) step(1, 1);

    // Reset mid-stream, then relock in 65 beats
    do_reset(0);
    chk("mrst_lock", 64'(block_lock), 64'(0));
    chk("mrst_off", 64'(bit_offset), 64'(0));
    chk("mrst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    for (int i = 1; i <= 65; i++) begin
      step(1, 1);
      if (i == 64) chk("relock_pre65", 64'(block_lock), 64'(0));
    end
    chk("relock_at65", 64'(block_lock), 64'(1));

    // 15 bad headers in one window: lock held
    wait_window();
    bad_pending = 15;
    repeat (100) step(1, 1);
    chk("bad15_lock", 64'(block_lock), 64'(1));
    chk("bad15_off", 64'(bit_offset), 64'(0));

    // 16 bad headers in one window: lock dropped, one slip
    wait_window();
    bad_pending = 16;
    n = 0;
    while (m_lock && n < 40) begin step(1, 1); n++; end
    chk("bad16_lock", 64'(block_lock), 64'(0));
    chk("bad16_off", 64'(bit_offset), 64'(1));
    chk("bad16_tvalid", 64'(bus.m_axis_tvalid), 64'(0));

    // Stream shifted by 37 bits
    do_reset(37);
    n = 0;
    while (!block_lock && n < 400) begin step(1, 1); n++; end
    chk("s37_lock", 64'(block_lock), 64'(1));
    chk("s37_off", 64'(bit_offset), 64'(37));
    chk("s37_min_beats", 64'(n >= 1 + 37 * (SLIP_WAIT + 1) + LOCK_CNT), 64'(1));
    repeat (40) step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);

    // Offset 65, then a forced slip wraps to 0
    do_reset(65);
    n = 0;
    while (!block_lock && n < 700) begin step(1, 1); n++; end
    chk("s65_lock", 64'(block_lock), 64'(1));
    chk("s65_off", 64'(bit_offset), 64'(65));
    wait_window();
    bad_pending = 16;
    n = 0;
    while (m_lock && n < 40) begin step(1, 1); n++; end
    chk("wrap_lock", 64'(block_lock), 64'(0));
    chk("wrap_off", 64'(bit_offset), 64'(0));
    chk("wrap_tvalid", 64'(bus.m_axis_tvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
